// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back requesters, the register file write port and issue logic.
// The arbiter takes the slave view; the driving environment takes the master view.
interface regfile_wb_arbiter_if;
    logic        exe_valid;
    logic        exe_ready;
    logic [0:4]  exe_addr;
    logic [0:63] exe_data;
    logic [0:2]  exe_ppp;

    logic        mem_valid;
    logic        mem_ready;
    logic [0:4]  mem_addr;
    logic [0:63] mem_data;
    logic [0:2]  mem_ppp;

    logic        wb_en;
    logic [0:4]  wb_addr;
    logic [0:63] wb_data;
    logic [0:2]  wb_ppp;

    logic        issue_set;
    logic [0:4]  issue_addr;
    logic        issue_ready;

    logic [0:4]  chk_a_addr;
    logic [0:4]  chk_b_addr;
    logic        chk_a_busy;
    logic        chk_b_busy;
    logic        err;

    modport slave (
        input  exe_valid, exe_addr, exe_data, exe_ppp,
        input  mem_valid, mem_addr, mem_data, mem_ppp,
        input  issue_set, issue_addr, chk_a_addr, chk_b_addr,
        output exe_ready, mem_ready,
        output wb_en, wb_addr, wb_data, wb_ppp,
        output issue_ready, chk_a_busy, chk_b_busy, err
    );

    modport master (
        output exe_valid, exe_addr, exe_data, exe_ppp,
        output mem_valid, mem_addr, mem_data, mem_ppp,
        output issue_set, issue_addr, chk_a_addr, chk_b_addr,
        input  exe_ready, mem_ready,
        input  wb_en, wb_addr, wb_data, wb_ppp,
        input  issue_ready, chk_a_busy, chk_b_busy, err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the 32 x 64-bit register file, with a per-register
// outstanding-write scoreboard used by issue logic for RAW hazard detection.
//
// state    | meaning
// LAST_EXE | exe received the most recent grant; mem wins the next contention
// LAST_MEM | mem received the most recent grant; exe wins the next contention
module regfile_wb_arbiter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    regfile_wb_arbiter_if.slave bus
);
    typedef enum logic {LAST_EXE, LAST_MEM} grantState_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    grantState_t lastGrant;
    grantState_t lastGrantNext;
    logic        grantExe;
    logic        grantMem;
    logic        granted;

    logic [0:4]  selAddr;
    logic [0:63] selData;
    logic [0:2]  selPpp;

    logic        wbEnReg;
    logic [0:4]  wbAddrReg;
    logic [0:63] wbDataReg;
    logic [0:2]  wbPppReg;
    logic        errReg;

    logic [CNT_W-1:0] cntReg [1:31];
    logic [CNT_W-1:0] cnt [0:31];
    logic             issueReady;
    logic             issueInc;

    always_ff @(posedge clk) begin
        if (reset) lastGrant <= LAST_EXE;
        else       lastGrant <= lastGrantNext;
    end

    always_comb begin
        grantExe      = 1'b0;
        grantMem      = 1'b0;
        lastGrantNext = lastGrant;
        if (!reset) begin
            if (bus.exe_valid && (!bus.mem_valid || lastGrant == LAST_MEM)) grantExe = 1'b1;
            else if (bus.mem_valid)                                         grantMem = 1'b1;
        end
        if (grantExe)      lastGrantNext = LAST_EXE;
        else if (grantMem) lastGrantNext = LAST_MEM;
    end

    assign granted = grantExe || grantMem;
    assign selAddr = grantExe ? bus.exe_addr : bus.mem_addr;
    assign selData = grantExe ? bus.exe_data : bus.mem_data;
    assign selPpp  = grantExe ? bus.exe_ppp  : bus.mem_ppp;

    // Writes to r0 complete the handshake but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbEnReg   <= 1'b0;
            wbAddrReg <= '0;
            wbDataReg <= '0;
            wbPppReg  <= '0;
        end else begin
            wbEnReg <= granted && (selAddr != 5'd0);
            if (granted) begin
                wbAddrReg <= selAddr;
                wbDataReg <= selData;
                wbPppReg  <= selPpp;
            end
        end
    end

    always_comb begin
        cnt[0] = '0;
        for (int i = 1; i < 32; i++) cnt[i] = cntReg[i];
    end

    assign issueReady = !reset && (cnt[bus.issue_addr] != CNT_MAX);
    assign issueInc   = bus.issue_set && issueReady && (bus.issue_addr != 5'd0);

    // Decrement lands on the same edge the register file commits the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) cntReg[i] <= '0;
            errReg <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (issueInc && bus.issue_addr == 5'(i)) begin
                    if (!(wbEnReg && wbAddrReg == 5'(i))) cntReg[i] <= cntReg[i] + 1'b1;
                end else if (wbEnReg && wbAddrReg == 5'(i)) begin
                    if (cntReg[i] == '0) errReg <= 1'b1;
                    else                 cntReg[i] <= cntReg[i] - 1'b1;
                end
            end
        end
    end

    assign bus.exe_ready   = grantExe;
    assign bus.mem_ready   = grantMem;
    assign bus.wb_en       = wbEnReg;
    assign bus.wb_addr     = wbAddrReg;
    assign bus.wb_data     = wbDataReg;
    assign bus.wb_ppp      = wbPppReg;
    assign bus.issue_ready = issueReady;
    assign bus.chk_a_busy  = !reset && (cnt[bus.chk_a_addr] != '0);
    assign bus.chk_b_busy  = !reset && (cnt[bus.chk_b_addr] != '0);
    assign bus.err         = errReg;
endmodule
